aes_key_expander: RTL and testbench

//  Word-serial AES key-schedule engine: AES-128 and AES-256, plus AES-192 when the build enables it.

---
 rtl/aes_key_expander.sv | 174 +++++++++++++++++
 tb/tb_aes_key_expander.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Word-serial AES key schedule (AES-128/256, AES-192 with AES_KEY_192_EN) using an external shared
// S-box; all round keys are kept in a 60-word store and read combinationally by round index.
module aes_key_expander #(
  parameter int SBOX_LAT  = 1,
  parameter int MEM_WORDS = 60
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [255:0] key,
  input  logic [1:0]   keylen,
  input  logic         key_init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         key_ready,
  output logic         busy,
  output logic         key_err,
  output logic [3:0]   num_rounds,
  output logic [31:0]  sbox_feed,
  input  logic [31:0]  new_sbox,
  output logic [2:0]   state_dbg
);

  // Handshakes: key_init is a one-cycle request honoured only in IDLE; key_ready rises once every
  // round key is stored and holds until the next accepted request. sbox_feed is registered and
  // new_sbox must carry SubWord(sbox_feed) exactly SBOX_LAT cycles later; it is sampled only on
  // the SUB write cycle.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXPAND, S_SUB, S_DONE} state_t;

  localparam logic [1:0] LAT = 2'(SBOX_LAT);

  state_t      state;
  logic [31:0] w [MEM_WORDS];
  logic [5:0]  i_idx;
  logic [3:0]  j_idx;      // i_idx mod nk, kept as a counter to avoid a divider
  logic [3:0]  nk;
  logic [5:0]  total;
  logic [7:0]  rcon;
  logic [1:0]  lat_cnt;

  logic        key_legal;
  logic [3:0]  nk_sel;
  logic [3:0]  nr_sel;

  always_comb begin
    key_legal = 1'b1;
    nk_sel    = 4'd4;
    nr_sel    = 4'd10;
    case (keylen)
      2'b00: begin
        nk_sel = 4'd4;
        nr_sel = 4'd10;
      end
`ifdef AES_KEY_192_EN
      2'b01: begin
        nk_sel = 4'd6;
        nr_sel = 4'd12;
      end
`endif
      2'b10: begin
        nk_sel = 4'd8;
        nr_sel = 4'd14;
      end
      default: key_legal = 1'b0;
    endcase
  end

  logic [31:0] w_prev;
  logic [31:0] w_back;
  logic [5:0]  i_next;
  logic [3:0]  j_next;
  logic        last_word;
  logic [7:0]  rcon_next;

  assign w_prev    = w[i_idx - 6'd1];
  assign w_back    = w[i_idx - {2'b00, nk}];
  assign i_next    = i_idx + 6'd1;
  assign j_next    = (j_idx == 4'(nk - 4'd1)) ? 4'd0 : j_idx + 4'd1;
  assign last_word = (i_next == total);
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      for (int k = 0; k < MEM_WORDS; k++) w[k] <= '0;
      i_idx      <= '0;
      j_idx      <= '0;
      nk         <= 4'd4;
      total      <= 6'd44;
      rcon       <= '0;
      lat_cnt    <= '0;
      sbox_feed  <= '0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      key_err    <= 1'b0;
      num_rounds <= 4'd10;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_init) begin
            if (key_legal) begin
              key_ready  <= 1'b0;
              busy       <= 1'b1;
              key_err    <= 1'b0;
              nk         <= nk_sel;
              num_rounds <= nr_sel;
              total      <= {nr_sel, 2'b00} + 6'd4;
              rcon       <= 8'h01;
              state      <= S_LOAD;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk) w[k] <= key[255 - 32*k -: 32];
          end
          i_idx <= {2'b00, nk};
          j_idx <= '0;
          state <= S_EXPAND;
        end
        S_EXPAND: begin
          if (j_idx == 4'd0) begin
            sbox_feed <= {w_prev[23:0], w_prev[31:24]};
            lat_cnt   <= '0;
            state     <= S_SUB;
          end else if (nk == 4'd8 && j_idx == 4'd4) begin
            sbox_feed <= w_prev;
            lat_cnt   <= '0;
            state     <= S_SUB;
          end else begin
            w[i_idx] <= w_back ^ w_prev;
            i_idx    <= i_next;
            j_idx    <= j_next;
            state    <= last_word ? S_DONE : S_EXPAND;
          end
        end
        S_SUB: begin
          if (lat_cnt == LAT) begin
            if (j_idx == 4'd0) begin
              w[i_idx] <= w_back ^ new_sbox ^ {rcon, 24'h0};
              rcon     <= rcon_next;
            end else begin
              w[i_idx] <= w_back ^ new_sbox;
            end
            i_idx <= i_next;
            j_idx <= j_next;
            state <= last_word ? S_DONE : S_EXPAND;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_DONE: begin
          key_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [5:0] rbase;
  assign rbase = {round, 2'b00};

  always_comb begin
    round_key = '0;
    if (round <= num_rounds)
      round_key = {w[rbase], w[6'(rbase + 6'd1)], w[6'(rbase + 6'd2)], w[6'(rbase + 6'd3)]};
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench: three expanders with S-box latency 0/1/2 share stimulus; a reference key
// schedule fills a scoreboard queue of round keys that is drained when each run completes.
module tb_aes_key_expander;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [255:0] key;
  logic [1:0]   keylen;
  logic         key_init;
  logic [3:0]   round;

  logic [127:0] round_key  [3];
  logic         key_ready  [3];
  logic         busy       [3];
  logic         key_err    [3];
  logic [3:0]   num_rounds [3];
  logic [31:0]  sbox_feed  [3];
  logic [2:0]   state_dbg  [3];

  logic [31:0]  nsb0, nsb1_q, nsb2_q1, nsb2_q2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q [$];
  logic [31:0]  mw [60];
  int m_nsb, m_plain, last_nr;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 aclk = ~aclk;

  aes_key_expander #(.SBOX_LAT(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .key(key), .keylen(keylen), .key_init(key_init),
    .round(round), .round_key(round_key[0]), .key_ready(key_ready[0]), .busy(busy[0]),
    .key_err(key_err[0]), .num_rounds(num_rounds[0]), .sbox_feed(sbox_feed[0]),
    .new_sbox(nsb0), .state_dbg(state_dbg[0]));

  aes_key_expander #(.SBOX_LAT(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .key(key), .keylen(keylen), .key_init(key_init),
    .round(round), .round_key(round_key[1]), .key_ready(key_ready[1]), .busy(busy[1]),
    .key_err(key_err[1]), .num_rounds(num_rounds[1]), .sbox_feed(sbox_feed[1]),
    .new_sbox(nsb1_q), .state_dbg(state_dbg[1]));

  aes_key_expander #(.SBOX_LAT(2)) u_dut2 (
    .aclk(aclk), .aresetn(aresetn), .key(key), .keylen(keylen), .key_init(key_init),
    .round(round), .round_key(round_key[2]), .key_ready(key_ready[2]), .busy(busy[2]),
    .key_err(key_err[2]), .num_rounds(num_rounds[2]), .sbox_feed(sbox_feed[2]),
    .new_sbox(nsb2_q2), .state_dbg(state_dbg[2]));

  // ---------------- AES arithmetic for the S-box and reference schedule ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_b(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] base = a;
    logic [7:0] e = 8'd254;
    logic [7:0] s;
    while (e != 0) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox_b(v[31:24]), sbox_b(v[23:16]), sbox_b(v[15:8]), sbox_b(v[7:0])};
  endfunction

  assign nsb0 = sub_word(sbox_feed[0]);
  always @(posedge aclk) nsb1_q <= sub_word(sbox_feed[1]);
  always @(posedge aclk) begin
    nsb2_q1 <= sub_word(sbox_feed[2]);
    nsb2_q2 <= nsb2_q1;
  end

  task automatic model_expand(input logic [255:0] k, input int nk);
    int t = 4 * (nk + 7);
    logic [7:0]  rc = 8'h01;
    logic [31:0] tmp;
    m_nsb = 0;
    for (int x = 0; x < 60; x++) mw[x] = '0;
    for (int x = 0; x < nk; x++) mw[x] = k[255 - 32*x -: 32];
    for (int x = nk; x < t; x++) begin
      tmp = mw[x-1];
      if (x % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
        m_nsb++;
      end else if (nk == 8 && x % nk == 4) begin
        tmp = sub_word(tmp);
        m_nsb++;
      end
      mw[x] = mw[x-nk] ^ tmp;
    end
    m_plain = (t - nk) - m_nsb;
  endtask

  task automatic push_expected(input int nr);
    for (int r = 0; r < 16; r++)
      for (int d = 0; d < 3; d++)
        exp_q.push_back((r <= nr) ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'h0);
  endtask

  task automatic push_zero();
    for (int r = 0; r < 16; r++)
      for (int d = 0; d < 3; d++) exp_q.push_back(128'h0);
  endtask

  task automatic check_store(input string tag);
    logic [127:0] e;
    for (int r = 0; r < 16; r++) begin
      round = 4'(r);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s scoreboard empty dut%0d round %0d", tag, d, r);
        end else begin
          e = exp_q.pop_front();
          if (round_key[d] !== e) begin
            n_fail++;
            $display("FAIL %s round_key dut%0d round %0d: got %h expected %h", tag, d, r, round_key[d], e);
          end
        end
      end
    end
  endtask

  task automatic check_round_const(input string tag, input logic [3:0] r, input logic [127:0] e);
    round = r;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (round_key[d] !== e) begin
        n_fail++;
        $display("FAIL %s dut%0d round %0d: got %h expected %h", tag, d, r, round_key[d], e);
      end
    end
  endtask

  // Full expansion run; pulse_at>0 issues an extra key_init on that cycle of the run.
  task automatic run_key(input string tag, input logic [255:0] k, input logic [1:0] kl,
                         input int nk, input int pulse_at);
    int nr = nk + 6;
    int lat [3];
    bit done [3];
    bit all_done = 0;
    int lat_exp;
    model_expand(k, nk);
    push_expected(nr);
    @(negedge aclk);
    key = k; keylen = kl; key_init = 1'b1;
    @(posedge aclk); #1;
    key_init = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (busy[d] !== 1'b1 || key_err[d] !== 1'b0 || key_ready[d] !== 1'b0 ||
          num_rounds[d] !== 4'(nr)) begin
        n_fail++;
        $display("FAIL %s start dut%0d: busy=%b err=%b ready=%b nr=%0d expected 1 0 0 %0d",
                 tag, d, busy[d], key_err[d], key_ready[d], num_rounds[d], nr);
      end
      lat[d] = 0; done[d] = 0;
    end
    for (int c = 1; c <= 400 && !all_done; c++) begin
      @(posedge aclk); #1;
      if (pulse_at > 0 && c == pulse_at + 1) begin
        key_init = 1'b0; key = k; keylen = kl;
      end
      all_done = 1;
      for (int d = 0; d < 3; d++) begin
        if (!done[d] && key_ready[d] === 1'b1) begin
          done[d] = 1; lat[d] = c;
        end
        if (!done[d]) all_done = 0;
      end
      if (pulse_at > 0 && c == pulse_at) begin
        for (int d = 0; d < 3; d++) begin
          n_tests++;
          if (busy[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy at pulse dut%0d: got %b expected 1", tag, d, busy[d]);
          end
        end
        key = ~k; keylen = 2'b00; key_init = 1'b1;
      end
    end
    for (int d = 0; d < 3; d++) begin
      lat_exp = 2 + m_plain + m_nsb * (2 + d);
      n_tests++;
      if (!done[d]) begin
        n_fail++;
        $display("FAIL %s timeout dut%0d: key_ready never rose, expected at edge %0d", tag, d, lat_exp);
      end else if (lat[d] != lat_exp) begin
        n_fail++;
        $display("FAIL %s latency dut%0d: got %0d expected %0d", tag, d, lat[d], lat_exp);
      end
      n_tests++;
      if (busy[d] !== 1'b0 || key_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end dut%0d: busy=%b err=%b expected 0 0", tag, d, busy[d], key_err[d]);
      end
    end
    if (nk == 4) begin
      n_tests++;
      if (lat[1] != 62) begin
        n_fail++;
        $display("FAIL %s aes128 lat1 latency: got %0d expected 62", tag, lat[1]);
      end
    end
    check_store(tag);
    last_nr = nr;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; key = '0; keylen = 2'b00; key_init = 1'b0; round = 4'd0;
    #12;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (key_ready[d] !== 1'b0 || busy[d] !== 1'b0 || key_err[d] !== 1'b0 ||
          num_rounds[d] !== 4'd10 || sbox_feed[d] !== 32'h0 || state_dbg[d] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: ready=%b busy=%b err=%b nr=%0d feed=%h st=%0d expected 0 0 0 10 0 0",
                 d, key_ready[d], busy[d], key_err[d], num_rounds[d], sbox_feed[d], state_dbg[d]);
      end
    end
    push_zero();
    check_store("reset_store");
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_aes128();
    run_key("aes128", K128, 2'b00, 4, 0);
    check_round_const("aes128_r0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check_round_const("aes128_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  task automatic test_aes256();
    run_key("aes256", K256, 2'b10, 8, 0);
    check_round_const("aes256_r14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
  endtask

  task automatic test_rejected(input string tag, input logic [1:0] kl);
    @(negedge aclk);
    key = ~key; keylen = kl; key_init = 1'b1;
    @(posedge aclk); #1;
    key_init = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (key_err[d] !== 1'b1 || busy[d] !== 1'b0 || key_ready[d] !== 1'b1 ||
          num_rounds[d] !== 4'(last_nr) || state_dbg[d] !== 3'd0) begin
        n_fail++;
        $display("FAIL %s dut%0d: err=%b busy=%b ready=%b nr=%0d st=%0d expected 1 0 1 %0d 0",
                 tag, d, key_err[d], busy[d], key_ready[d], num_rounds[d], state_dbg[d], last_nr);
      end
    end
    push_expected(last_nr);
    check_store(tag);
  endtask

  task automatic test_aes192();
`ifdef AES_KEY_192_EN
    run_key("aes192", K192, 2'b01, 6, 0);
    check_round_const("aes192_r12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
`else
    test_rejected("aes192_off", 2'b01);
`endif
  endtask

  task automatic test_illegal();
    test_rejected("illegal_11", 2'b11);
  endtask

  task automatic test_init_while_busy();
    run_key("busy_init", K128, 2'b00, 4, 20);
    check_round_const("busy_init_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    key = K256; keylen = 2'b10; key_init = 1'b1;
    @(posedge aclk); #1;
    key_init = 1'b0;
    repeat (35) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (key_ready[d] !== 1'b0 || busy[d] !== 1'b0 || num_rounds[d] !== 4'd10 ||
          sbox_feed[d] !== 32'h0 || state_dbg[d] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d: ready=%b busy=%b nr=%0d feed=%h st=%0d expected 0 0 10 0 0",
                 d, key_ready[d], busy[d], num_rounds[d], sbox_feed[d], state_dbg[d]);
      end
    end
    push_zero();
    check_store("reset_mid_store");
    @(negedge aclk);
    aresetn = 1'b1;
    run_key("after_reset", K128, 2'b00, 4, 0);
    check_round_const("after_reset_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_aes256();
    test_aes192();
    test_illegal();
    test_init_while_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
